// File: rtl/mole_round_if.sv
// Signal bundle between the game controller side and the mole round engine.
// The engine takes the slave view; the controller/top level takes the master view.
interface mole_round_if #(
    parameter int N_HOLES = 4
);
    logic               play;
    logic               display_score;
    logic [N_HOLES-1:0] whack;
    logic [N_HOLES-1:0] mole;
    logic [11:0]        score_bcd;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               round_active;

    modport master (
        output play,
        output display_score,
        output whack,
        input  mole,
        input  score_bcd,
        input  hit_pulse,
        input  miss_pulse,
        input  round_active
    );

    modport slave (
        input  play,
        input  display_score,
        input  whack,
        output mole,
        output score_bcd,
        output hit_pulse,
        output miss_pulse,
        output round_active
    );
endinterface

// File: rtl/mole_round_engine.sv
// Mole round engine: raises one mole at a time on a pseudo-random hole while
// play is high, times the whack window, judges button edges as hit or miss and
// keeps a saturating 3-digit BCD score for the HEX display path.
module mole_round_engine #(
    parameter int         N_HOLES       = 4,
    parameter int         WINDOW_CYCLES = 25000000,
    parameter int         GAP_CYCLES    = 12500000,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input logic         clk,
    input logic         reset,
    mole_round_if.slave bus
);

    localparam int HW      = (N_HOLES > 2) ? $clog2(N_HOLES) : 1;
    localparam int CNT_MAX = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [N_HOLES-1:0] ONE_HOT0 = N_HOLES'(1);

    typedef enum logic [1:0] {
        IDLE,
        SPAWN,
        UP,
        GAP
    } state_t;

    state_t             state, state_n;
    logic [7:0]         lfsr;
    logic [CW-1:0]      counter, counter_n;
    logic [HW-1:0]      hole, hole_n;
    logic [N_HOLES-1:0] whack_q;
    logic               play_q;
    logic [N_HOLES-1:0] mole_r, mole_n;
    logic [11:0]        score_r, score_n;
    logic               hit_r, hit_n;
    logic               miss_r, miss_n;

    logic               lfsr_fb;
    logic [HW-1:0]      lfsr_hole;
    logic [HW-1:0]      spawn_hole;
    logic [N_HOLES-1:0] hole_mask;
    logic [N_HOLES-1:0] whack_rise;
    logic               correct_rise;
    logic               wrong_rise;

    // Decimal increment with carry into tens and hundreds; 999 holds.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == 12'h999) begin
            r = v;
        end else if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else if (v[7:4] != 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = v[7:4] + 4'd1;
        end else begin
            r[3:0]  = 4'd0;
            r[7:4]  = 4'd0;
            r[11:8] = v[11:8] + 4'd1;
        end
        return r;
    endfunction

    // Hole selection, whack edge detection and hit/miss classification.
    always_comb begin
        lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        lfsr_hole = HW'(int'(lfsr) % N_HOLES);
        if (lfsr_hole == hole) begin
            spawn_hole = (lfsr_hole == HW'(N_HOLES - 1)) ? '0 : lfsr_hole + HW'(1);
        end else begin
            spawn_hole = lfsr_hole;
        end
        hole_mask    = ONE_HOT0 << hole;
        whack_rise   = bus.whack & ~whack_q;
        correct_rise = |(whack_rise & hole_mask);
        wrong_rise   = |(whack_rise & ~hole_mask);
    end

    // Next-state logic; abort conditions (display phase, play dropped) win over everything.
    always_comb begin
        state_n   = state;
        counter_n = counter;
        hole_n    = hole;
        mole_n    = '0;
        score_n   = score_r;
        hit_n     = 1'b0;
        miss_n    = 1'b0;

        if (bus.display_score || (state != IDLE && !bus.play)) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.play && !play_q) begin
                        state_n = SPAWN;
                        score_n = '0;
                    end
                end
                SPAWN: begin
                    hole_n    = spawn_hole;
                    counter_n = '0;
                    mole_n    = ONE_HOT0 << spawn_hole;
                    state_n   = UP;
                end
                UP: begin
                    mole_n    = hole_mask;
                    counter_n = counter + CW'(1);
                    if (correct_rise) begin
                        hit_n     = 1'b1;
                        score_n   = bcd_inc(score_r);
                        mole_n    = '0;
                        counter_n = '0;
                        state_n   = GAP;
                    end else if (counter == CW'(WINDOW_CYCLES - 1)) begin
                        miss_n    = 1'b1;
                        mole_n    = '0;
                        counter_n = '0;
                        state_n   = GAP;
                    end else if (wrong_rise) begin
                        miss_n = 1'b1;
                    end
                end
                GAP: begin
                    if (counter == CW'(GAP_CYCLES - 1)) begin
                        counter_n = '0;
                        state_n   = SPAWN;
                    end else begin
                        counter_n = counter + CW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, LFSR, edge-history and registered output updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lfsr    <= LFSR_SEED;
            counter <= '0;
            hole    <= '0;
            whack_q <= '0;
            play_q  <= 1'b0;
            mole_r  <= '0;
            score_r <= '0;
            hit_r   <= 1'b0;
            miss_r  <= 1'b0;
        end else begin
            state   <= state_n;
            lfsr    <= {lfsr[6:0], lfsr_fb};
            counter <= counter_n;
            hole    <= hole_n;
            whack_q <= bus.whack;
            play_q  <= bus.play;
            mole_r  <= mole_n;
            score_r <= score_n;
            hit_r   <= hit_n;
            miss_r  <= miss_n;
        end
    end

    assign bus.mole         = mole_r;
    assign bus.score_bcd    = score_r;
    assign bus.hit_pulse    = hit_r;
    assign bus.miss_pulse   = miss_r;
    assign bus.round_active = (state != IDLE);

endmodule
